imem_fetch_ctrl: RTL and testbench
==================================

Name: imem_fetch_ctrl

Overview:
- Sequencer and owner of the instruction-memory port.
- Boot: arbitrates the port to a program loader (word writes) until the loader signals done.
- Run: owns the PC, issues fetch addresses, and registers instruction/PC into the IF/ID boundary with stall, redirect and fault handling.
- Sits between the instruction memory (combinational read, synchronous write) and the decode stage.

Parameters:
- RESET_PC, 32'h00000000, PC loaded on entry to RUN.
- DEPTH, 1024, instruction memory depth in 32-bit words; legal word index 0..DEPTH-1.
- NOP, 32'h00000013, instruction emitted on bubbles and faults.
- BOOT_LOAD, 1, 1 = reset enters LOAD; 0 = reset enters RUN directly.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- stall_i  input  1  decode stall: hold PC and IF/ID outputs.
- redirect_i  input  1  branch/jump redirect request.
- redirect_pc_i  input  32  redirect target byte address.
- ld_valid_i  input  1  loader write request.
- ld_addr_i  input  32  loader byte address (word aligned).
- ld_data_i  input  32  loader write data.
- ld_done_i  input  1  loader finished; start execution.
- ld_ready_o  output  1  high in LOAD: loader writes are accepted.
- ld_count_o  output  11  number of accepted (in-range) loader writes.
- imem_addr_o  output  32  memory address: ld_addr_i in LOAD, PC otherwise.
- imem_we_o  output  1  memory write enable.
- imem_wdata_o  output  32  memory write data (= ld_data_i).
- imem_rdata_i  input  32  memory read data, combinational from imem_addr_o.
- instr_o  output  32  IF/ID instruction register.
- pc_o  output  32  IF/ID PC register.
- valid_o  output  1  instr_o/pc_o hold a real fetched instruction.
- halted_o  output  1  core halted on fetch fault.

Behaviour:
- Reset is checked first at every edge:
  - state = LOAD if BOOT_LOAD else RUN.
  - pc = RESET_PC; instr_o = NOP; pc_o = 0; valid_o = 0; ld_count_o = 0; halted_o = 0.
- A mid-operation reset aborts loading or execution identically; memory contents are untouched.
- States: LOAD, RUN, HALT.
- LOAD:
  - ld_ready_o = 1; imem_addr_o = ld_addr_i.
  - imem_we_o = ld_valid_i AND ld_addr_i[1:0]==0 AND ld_addr_i[31:2] < DEPTH, combinational.
  - Each accepted write increments ld_count_o; illegal (misaligned or out-of-range) writes are dropped silently and not counted.
  - ld_done_i → RUN next cycle with pc = RESET_PC, valid_o = 0.
  - ld_valid_i and ld_done_i in the same cycle: the write is performed, then the transition happens.
  - stall_i and redirect_i are ignored.
- RUN:
  - ld_ready_o = 0; imem_we_o = 0; loader inputs ignored.
  - imem_addr_o = pc. Fetch latency is 1 cycle: the instruction at pc appears on instr_o the edge after pc is driven.
  - Priority each edge: redirect_i > fault > stall_i > normal.
  - redirect_i, target aligned: pc = redirect_pc_i; instr_o = NOP; valid_o = 0 (one bubble). This applies even when stall_i is high.
  - redirect_i, target misaligned (redirect_pc_i[1:0] != 0): go to HALT.
  - Fault: pc[31:2] >= DEPTH while not redirecting → HALT; instr_o = NOP; valid_o = 0. No wrap-around.
  - stall_i: pc, instr_o, pc_o, valid_o all hold.
  - Normal: instr_o = imem_rdata_i; pc_o = pc; valid_o = 1; pc = pc + 4 (32-bit, modulo 2^32).
- HALT:
  - halted_o = 1; valid_o = 0; instr_o = NOP; pc frozen at the faulting or target address.
  - All inputs ignored; exit only via rst.
- ld_count_o saturates at 2047.

Decomposition:
- Shared package (imem_pkg):
  - State encoding constants ST_LOAD = 2'd0, ST_RUN = 2'd1, ST_HALT = 2'd2.
  - NOP_INSTR constant and default IMEM_DEPTH, shared with the instruction memory.
- One natural sub-module, imem_ifid_reg: the IF/ID output register with hold (stall) and flush (bubble) inputs. It is reusable by the other pipeline stage registers.
- The FSM, PC and port mux stay in imem_fetch_ctrl.

Test Plan:
- Load and start: after rst, write 0x00500093 @0x0, 0x00A00113 @0x4; pulse ld_done_i → ld_count_o = 2; cycle after RUN entry valid_o = 1, pc_o = 0x0, instr_o = 0x00500093; next cycle pc_o = 0x4.
- Illegal loads: ld_addr_i = 0x2 and 0x1000 (DEPTH = 1024) → imem_we_o = 0, ld_count_o unchanged; ld_valid_i + ld_done_i together at 0x8 → write occurs, ld_count_o increments, state = RUN.
- Stall: stall_i high for 3 cycles at pc_o = 0x8 → instr_o/pc_o/valid_o constant; fetch resumes at 0xC.
- Redirect with stall: redirect_i = 1, redirect_pc_i = 0x40, stall_i = 1 → next cycle valid_o = 0, instr_o = 0x00000013; following cycle pc_o = 0x40, valid_o = 1.
- Faults: redirect to 0x42 → halted_o = 1, valid_o = 0 permanently; separately, sequential fetch reaching 0x1000 → halted_o = 1, no wrap to 0x0.
- Reset mid-run: assert rst while valid_o = 1 → next cycle valid_o = 0, ld_ready_o = 1, ld_count_o = 0, previously loaded words still readable after ld_done_i.

Source files
------------

// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory fetch path: state encoding,
// the default memory geometry and the IF/ID payload.
package imem_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned IMEM_DEPTH = 1024;
  localparam int unsigned LD_CNT_W   = 11;

  localparam logic [XLEN-1:0]     NOP_INSTR  = 32'h0000_0013;
  localparam logic [LD_CNT_W-1:0] LD_CNT_MAX = {LD_CNT_W{1'b1}};

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } ifid_payload_t;

  // Word-aligned and inside the memory.
  function automatic logic word_addr_ok(input logic [XLEN-1:0] addr,
                                        input int unsigned depth);
    return (addr[1:0] == 2'b00) && (addr[XLEN-1:2] < (XLEN-2)'(depth));
  endfunction

endpackage

// File: rtl/imem_ifid_reg.sv
// Pipeline boundary register with hold (stall) and flush (bubble insertion).
// Flush wins over hold so a redirect can squash a stalled stage.
module imem_ifid_reg
  import imem_pkg::*;
#(
  parameter logic [XLEN-1:0] NOP_VAL = NOP_INSTR
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          hold_i,
  input  logic          flush_i,
  input  ifid_payload_t d_i,
  input  logic          valid_i,
  output ifid_payload_t q_o,
  output logic          valid_o
);

  ifid_payload_t r_q;
  logic          r_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q.instr <= NOP_VAL;
      r_q.pc    <= '0;
      r_valid   <= 1'b0;
    end else if (flush_i) begin
      r_q.instr <= NOP_VAL;
      r_valid   <= 1'b0;
    end else if (!hold_i) begin
      r_q     <= d_i;
      r_valid <= valid_i;
    end
  end

  assign q_o     = r_q;
  assign valid_o = r_valid;

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Instruction-memory port owner: boot-time loader arbitration, then PC
// sequencing into the IF/ID register with stall, redirect and fault handling.
module imem_fetch_ctrl
  import imem_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned     DEPTH     = IMEM_DEPTH,
  parameter logic [XLEN-1:0] NOP       = NOP_INSTR,
  parameter bit              BOOT_LOAD = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall_i,
  input  logic                redirect_i,
  input  logic [XLEN-1:0]     redirect_pc_i,
  input  logic                ld_valid_i,
  input  logic [XLEN-1:0]     ld_addr_i,
  input  logic [XLEN-1:0]     ld_data_i,
  input  logic                ld_done_i,
  output logic                ld_ready_o,
  output logic [LD_CNT_W-1:0] ld_count_o,
  output logic [XLEN-1:0]     imem_addr_o,
  output logic                imem_we_o,
  output logic [XLEN-1:0]     imem_wdata_o,
  input  logic [XLEN-1:0]     imem_rdata_i,
  output logic [XLEN-1:0]     instr_o,
  output logic [XLEN-1:0]     pc_o,
  output logic                valid_o,
  output logic                halted_o
);

  localparam fetch_state_e RST_STATE = BOOT_LOAD ? ST_LOAD : ST_RUN;

  fetch_state_e        r_state, w_state_nxt;
  logic [XLEN-1:0]     r_pc, w_pc_nxt;
  logic [LD_CNT_W-1:0] r_ld_count, w_ld_count_nxt;
  logic                w_ld_we;
  logic                w_pc_oob;
  logic                w_hold;
  logic                w_flush;
  ifid_payload_t       w_ifid_d;
  ifid_payload_t       w_ifid_q;

  assign w_ld_we  = (r_state == ST_LOAD) && ld_valid_i && word_addr_ok(ld_addr_i, DEPTH);
  assign w_pc_oob = (r_pc[XLEN-1:2] >= (XLEN-2)'(DEPTH));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= RST_STATE;
      r_pc       <= RESET_PC;
      r_ld_count <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_ld_count <= w_ld_count_nxt;
    end
  end

  // Next state, PC and IF/ID control; redirect > fault > stall > normal.
  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_ld_count_nxt = r_ld_count;
    w_hold         = 1'b0;
    w_flush        = 1'b0;
    case (r_state)
      ST_LOAD: begin
        w_flush = 1'b1;
        if (w_ld_we && (r_ld_count != LD_CNT_MAX)) begin
          w_ld_count_nxt = r_ld_count + LD_CNT_W'(1);
        end
        if (ld_done_i) begin
          w_state_nxt = ST_RUN;
          w_pc_nxt    = RESET_PC;
        end
      end
      ST_RUN: begin
        if (redirect_i) begin
          w_flush  = 1'b1;
          w_pc_nxt = redirect_pc_i;
          if (redirect_pc_i[1:0] != 2'b00) begin
            w_state_nxt = ST_HALT;
          end
        end else if (w_pc_oob) begin
          w_flush     = 1'b1;
          w_state_nxt = ST_HALT;
        end else if (stall_i) begin
          w_hold = 1'b1;
        end else begin
          w_pc_nxt = r_pc + XLEN'(4);
        end
      end
      ST_HALT: begin
        w_flush = 1'b1;
      end
      default: begin
        w_flush     = 1'b1;
        w_state_nxt = ST_HALT;
      end
    endcase
  end

  assign w_ifid_d.instr = imem_rdata_i;
  assign w_ifid_d.pc    = r_pc;

  imem_ifid_reg #(
    .NOP_VAL (NOP)
  ) u_ifid (
    .clk     (clk),
    .rst     (rst),
    .hold_i  (w_hold),
    .flush_i (w_flush),
    .d_i     (w_ifid_d),
    .valid_i (1'b1),
    .q_o     (w_ifid_q),
    .valid_o (valid_o)
  );

  // Memory port mux: loader owns the port only while loading.
  assign ld_ready_o   = (r_state == ST_LOAD);
  assign imem_addr_o  = (r_state == ST_LOAD) ? ld_addr_i : r_pc;
  assign imem_we_o    = w_ld_we;
  assign imem_wdata_o = ld_data_i;

  assign ld_count_o = r_ld_count;
  assign instr_o    = w_ifid_q.instr;
  assign pc_o       = w_ifid_q.pc;
  assign halted_o   = (r_state == ST_HALT);

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed bench for imem_fetch_ctrl with a behavioural 1024-word memory.
module tb_imem_fetch_ctrl;

  localparam logic [31:0] NOP_V = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_i, redirect_i, ld_valid_i, ld_done_i;
  logic [31:0] redirect_pc_i, ld_addr_i, ld_data_i;
  logic        ld_ready_o, imem_we_o, valid_o, halted_o;
  logic [10:0] ld_count_o;
  logic [31:0] imem_addr_o, imem_wdata_o, imem_rdata_i, instr_o, pc_o;

  logic [31:0] mem [0:1023];
  int          n_checks = 0;
  int          n_fail   = 0;

  always #5 clk = ~clk;

  always @(posedge clk) if (imem_we_o) mem[imem_addr_o[11:2]] <= imem_wdata_o;
  assign imem_rdata_i = mem[imem_addr_o[11:2]];

  imem_fetch_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .ld_valid_i    (ld_valid_i),
    .ld_addr_i     (ld_addr_i),
    .ld_data_i     (ld_data_i),
    .ld_done_i     (ld_done_i),
    .ld_ready_o    (ld_ready_o),
    .ld_count_o    (ld_count_o),
    .imem_addr_o   (imem_addr_o),
    .imem_we_o     (imem_we_o),
    .imem_wdata_o  (imem_wdata_o),
    .imem_rdata_i  (imem_rdata_i),
    .instr_o       (instr_o),
    .pc_o          (pc_o),
    .valid_o       (valid_o),
    .halted_o      (halted_o)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0BAD_0000 | 32'(i);
    rst = 1'b1; stall_i = 0; redirect_i = 0; redirect_pc_i = 0;
    ld_valid_i = 0; ld_addr_i = 0; ld_data_i = 0; ld_done_i = 0;
    tick(); tick();
    rst = 1'b0;

    check_eq("rst_ready",  32'(ld_ready_o), 32'd1);
    check_eq("rst_valid",  32'(valid_o),    32'd0);
    check_eq("rst_instr",  instr_o,         NOP_V);
    check_eq("rst_pc",     pc_o,            32'h0);
    check_eq("rst_count",  32'(ld_count_o), 32'd0);
    check_eq("rst_halted", 32'(halted_o),   32'd0);

    // Loader writes: two legal, then misaligned and out-of-range.
    ld_valid_i = 1; ld_addr_i = 32'h0; ld_data_i = 32'h0050_0093; #1;
    check_eq("ld0_we", 32'(imem_we_o), 32'd1);
    check_eq("ld0_addr", imem_addr_o, 32'h0);
    tick();
    ld_addr_i = 32'h4; ld_data_i = 32'h00A0_0113; tick();
    ld_addr_i = 32'h2; ld_data_i = 32'hDEAD_0002; #1;
    check_eq("ld_misal_we", 32'(imem_we_o), 32'd0);
    tick();
    ld_addr_i = 32'h1000; ld_data_i = 32'hDEAD_1000; #1;
    check_eq("ld_oor_we", 32'(imem_we_o), 32'd0);
    tick();
    check_eq("ld_count2", 32'(ld_count_o), 32'd2);

    // Write and done in the same cycle.
    ld_addr_i = 32'h8; ld_data_i = 32'h0000_0213; ld_done_i = 1; #1;
    check_eq("ld_done_we", 32'(imem_we_o), 32'd1);
    tick();
    ld_valid_i = 0; ld_done_i = 0;
    check_eq("run_ready",  32'(ld_ready_o), 32'd0);
    check_eq("run_count3", 32'(ld_count_o), 32'd3);
    check_eq("run_valid0", 32'(valid_o),    32'd0);
    check_eq("run_addr0",  imem_addr_o,     32'h0);
    check_eq("mem8",       mem[2],          32'h0000_0213);
    ld_valid_i = 1; ld_addr_i = 32'h20; #1;
    check_eq("run_ld_we", 32'(imem_we_o), 32'd0);
    ld_valid_i = 0;

    tick();
    check_eq("f0_valid", 32'(valid_o), 32'd1);
    check_eq("f0_pc",    pc_o,         32'h0);
    check_eq("f0_instr", instr_o,      32'h0050_0093);
    tick();
    check_eq("f1_pc",    pc_o,    32'h4);
    check_eq("f1_instr", instr_o, 32'h00A0_0113);
    tick();
    check_eq("f2_pc",    pc_o,    32'h8);
    check_eq("f2_instr", instr_o, 32'h0000_0213);

    // Three stalled cycles hold everything at pc_o = 0x8.
    stall_i = 1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check_eq("stall_pc",    pc_o,         32'h8);
      check_eq("stall_instr", instr_o,      32'h0000_0213);
      check_eq("stall_valid", 32'(valid_o), 32'd1);
    end
    stall_i = 0;
    tick();
    check_eq("resume_pc",    pc_o,    32'hC);
    check_eq("resume_instr", instr_o, 32'h0BAD_0003);

    // Redirect wins over a concurrent stall.
    redirect_i = 1; redirect_pc_i = 32'h40; stall_i = 1;
    tick();
    redirect_i = 0; stall_i = 0;
    check_eq("redir_valid", 32'(valid_o), 32'd0);
    check_eq("redir_instr", instr_o,      NOP_V);
    tick();
    check_eq("redir_pc",    pc_o,         32'h40);
    check_eq("redir_v1",    32'(valid_o), 32'd1);
    check_eq("redir_ins1",  instr_o,      32'h0BAD_0010);

    // Reset mid-run returns to LOAD; memory contents survive.
    do_reset();
    check_eq("mrst_valid", 32'(valid_o),    32'd0);
    check_eq("mrst_ready", 32'(ld_ready_o), 32'd1);
    check_eq("mrst_count", 32'(ld_count_o), 32'd0);
    check_eq("mrst_instr", instr_o,         NOP_V);
    ld_done_i = 1; tick(); ld_done_i = 0;
    tick();
    check_eq("mrst_f0_pc",    pc_o,    32'h0);
    check_eq("mrst_f0_instr", instr_o, 32'h0050_0093);

    // Misaligned redirect halts permanently.
    redirect_i = 1; redirect_pc_i = 32'h42; tick();
    redirect_pc_i = 32'h40;
    check_eq("mis_halted", 32'(halted_o), 32'd1);
    check_eq("mis_valid",  32'(valid_o),  32'd0);
    check_eq("mis_instr",  instr_o,       NOP_V);
    check_eq("mis_addr",   imem_addr_o,   32'h42);
    tick(); tick();
    redirect_i = 0;
    check_eq("mis_halted2", 32'(halted_o), 32'd1);
    check_eq("mis_valid2",  32'(valid_o),  32'd0);
    check_eq("mis_addr2",   imem_addr_o,   32'h42);

    // Sequential fetch running off the end of memory faults, no wrap.
    do_reset();
    ld_done_i = 1; tick(); ld_done_i = 0;
    redirect_i = 1; redirect_pc_i = 32'hFF8; tick(); redirect_i = 0;
    tick();
    check_eq("end_pc_ff8", pc_o,         32'hFF8);
    check_eq("end_v_ff8",  32'(valid_o), 32'd1);
    tick();
    check_eq("end_pc_ffc", pc_o,          32'hFFC);
    check_eq("end_ins_ffc", instr_o,      32'h0BAD_03FF);
    tick();
    check_eq("oob_halted", 32'(halted_o), 32'd1);
    check_eq("oob_valid",  32'(valid_o),  32'd0);
    check_eq("oob_instr",  instr_o,       NOP_V);
    tick();
    check_eq("oob_addr",   imem_addr_o,   32'h1000);
    check_eq("oob_pc_o",   pc_o,          32'hFFC);
    check_eq("oob_halt2",  32'(halted_o), 32'd1);

    // Loader count saturates at 2047.
    do_reset();
    ld_valid_i = 1;
    for (int i = 0; i < 2050; i++) begin
      ld_addr_i = 32'(i % 1024) << 2;
      ld_data_i = 32'h5A00_0000 | 32'(i);
      tick();
    end
    ld_valid_i = 0;
    check_eq("cnt_sat", 32'(ld_count_o), 32'd2047);
    check_eq("cnt_sat_ready", 32'(ld_ready_o), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
